collatz_datapath: RTL and testbench

Datapath stage paired with the Collatz control FSM. It holds the seed, the 20-bit working value and the step counter, and applies the FSM's per-state control strobes. It feeds back `co`, `r` and `k`, which the FSM uses for its transitions. When the FSM returns to idle, it captures a result record and offers it downstream on a valid/ack handshake.

---
 rtl/collatz_datapath.sv | 130 +++++++++++++
 tb/tb_collatz_datapath.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_datapath.sv
// Collatz datapath: seed/working-value/step registers driven by FSM strobes, plus a
// valid/ack result record. Define COLLATZ_PEAK_EN to build the peak tracker.
module collatz_datapath #(
  parameter int KW = 20,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    seed_in,
  input  logic          seed_we,
  input  logic          mx,
  input  logic          rx,
  input  logic          ik,
  input  logic          pk,
  input  logic          sk,
  input  logic          mr,
  input  logic          pr,
  input  logic          ir,
  output logic [7:0]    co,
  output logic          r,
  output logic [KW-1:0] k,
  output logic          res_valid,
  input  logic          res_ack,
  output logic [SW-1:0] res_steps,
  output logic [KW-1:0] res_peak,
  output logic          res_ovf,
  output logic          res_drop
);

  logic [SW-1:0] steps;
  logic          ovf;
  logic          ir_q;
  logic [KW-1:0] co_ext;
  logic [KW+1:0] k_triple;
  logic          triple_ovf;
  logic          k_upd;
  logic [KW-1:0] k_next;
  logic          capture;
  logic          unused_pk;

  // pk carries no datapath meaning; it only completes the control bus
  assign unused_pk  = pk;
  assign co_ext     = {{(KW-8){1'b0}}, co};
  assign k_triple   = {2'b00, k} + {1'b0, k, 1'b0} + (KW+2)'(1);
  assign triple_ovf = |k_triple[KW+1:KW];
  assign r          = k[0];
  assign capture    = ir & ~ir_q;

  always_comb begin
    k_upd  = 1'b0;
    k_next = k;
    if (rx) begin
      k_upd  = 1'b1;
      k_next = co_ext;
    end else if (mx & mr) begin
      k_upd  = 1'b1;
      k_next = k_triple[KW-1:0];
    end else if (mx & pr) begin
      k_upd  = 1'b1;
      k_next = k >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co    <= '0;
      k     <= '0;
      steps <= '0;
      ovf   <= 1'b0;
    end else begin
      if (seed_we)
        co <= seed_in;
      k <= k_next;
      if (sk | rx)
        steps <= '0;
      else if (ik & mx && steps != '1)
        steps <= steps + 1'b1;
      if (rx)
        ovf <= 1'b0;
      else if (mx & mr & triple_ovf)
        ovf <= 1'b1;
    end
  end

`ifdef COLLATZ_PEAK_EN
  logic [KW-1:0] peak;
  logic [KW-1:0] res_peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak       <= '0;
      res_peak_q <= '0;
    end else begin
      if (rx)
        peak <= co_ext;
      else if (k_upd && k_next > peak)
        peak <= k_next;
      if (capture)
        res_peak_q <= peak;
    end
  end

  assign res_peak = res_peak_q;
`else
  assign res_peak = '0;
`endif

  // ir_q resets high so the idle level right after reset is not seen as a rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= 1'b1;
      res_valid <= 1'b0;
      res_steps <= '0;
      res_ovf   <= 1'b0;
      res_drop  <= 1'b0;
    end else begin
      ir_q <= ir;
      if (capture) begin
        res_valid <= 1'b1;
        res_steps <= steps;
        res_ovf   <= ovf;
        if (res_valid & ~res_ack)
          res_drop <= 1'b1;
      end else if (res_valid & res_ack) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_collatz_datapath.sv
// Randomized bench for collatz_datapath against an arithmetic Collatz/record model.
module tb_collatz_datapath;
  localparam int KW = 20;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seed_in = '0;
  logic          seed_we = 0, mx = 0, rx = 0, ik = 0, pk = 0, sk = 0, mr = 0, pr = 0, ir = 1, res_ack = 0;
  logic [7:0]    co;
  logic          r;
  logic [KW-1:0] k;
  logic          res_valid, res_ovf, res_drop;
  logic [SW-1:0] res_steps;
  logic [KW-1:0] res_peak;

  int total = 0;
  int bad = 0;

  // model state
  int m_co = 0, m_k = 0, m_steps = 0, m_peak = 0;
  bit m_ovf = 0;
  bit e_valid = 0, e_ovf = 0, e_drop = 0;
  int e_steps = 0, e_peak = 0;

  collatz_datapath #(.KW(KW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in), .seed_we(seed_we),
    .mx(mx), .rx(rx), .ik(ik), .pk(pk), .sk(sk), .mr(mr), .pr(pr), .ir(ir),
    .co(co), .r(r), .k(k), .res_valid(res_valid), .res_ack(res_ack),
    .res_steps(res_steps), .res_peak(res_peak), .res_ovf(res_ovf), .res_drop(res_drop)
  );

  always #5 clk = ~clk;

  function automatic int peak_view(input int p);
`ifdef COLLATZ_PEAK_EN
    return p;
`else
    return 0;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    seed_we = 0; mx = 0; rx = 0; ik = 0; pk = 0; sk = 0; mr = 0; pr = 0;
  endtask

  task automatic load_seed(input int v);
    seed_in = 8'(v); seed_we = 1;
    cycle();
    seed_we = 0;
    m_co = v;
  endtask

  task automatic start_run();
    ir = 0; rx = 1; sk = 1; ik = 1;
    cycle();
    clear_strobes();
    m_k = m_co; m_steps = 0; m_peak = m_co; m_ovf = 0;
  endtask

  task automatic model_triple();
    longint t;
    t = 3 * longint'(m_k) + 1;
    if (t >= (longint'(1) << KW)) m_ovf = 1;
    m_k = int'(t % (longint'(1) << KW));
    if (m_k > m_peak) m_peak = m_k;
    if (m_steps < 65535) m_steps++;
  endtask

  task automatic collatz_step(input bit we, input int sv);
    pk = 1'($urandom_range(0, 1));
    if (we) begin seed_we = 1; seed_in = 8'(sv); end
    if (m_k % 2 == 1) begin
      mx = 1; mr = 1; ik = 1; pr = 1'($urandom_range(0, 1));
      cycle();
      model_triple();
    end else begin
      mx = 1; pr = 1; ik = 1;
      cycle();
      m_k = m_k / 2;
      if (m_steps < 65535) m_steps++;
    end
    if (we) m_co = sv;
    clear_strobes();
  endtask

  task automatic mul_step();
    mx = 1; mr = 1; ik = 1; pr = 1'($urandom_range(0, 1));
    cycle();
    clear_strobes();
    model_triple();
  endtask

  task automatic noop_step();
    case ($urandom_range(0, 3))
      0: ik = 1;
      1: pr = 1;
      2: mr = 1;
      default: begin mx = 1; pk = 1; end
    endcase
    cycle();
    clear_strobes();
  endtask

  task automatic finish_run(input bit ack);
    ir = 1; res_ack = ack;
    cycle();
    res_ack = 0;
    if (e_valid && !ack) e_drop = 1;
    e_valid = 1; e_steps = m_steps; e_peak = peak_view(m_peak); e_ovf = m_ovf;
  endtask

  task automatic ack_cycle();
    res_ack = 1;
    cycle();
    res_ack = 0;
    e_valid = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (co !== 8'd0) begin bad++; $display("[TB] FAIL reset_co: got %0d expected 0", co); end
    total++; if (k !== '0) begin bad++; $display("[TB] FAIL reset_k: got %0d expected 0", k); end
    total++; if (r !== 1'b0) begin bad++; $display("[TB] FAIL reset_r: got %0b expected 0", r); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %0b expected 0", res_valid); end
    total++; if (res_steps !== '0) begin bad++; $display("[TB] FAIL reset_steps: got %0d expected 0", res_steps); end
    total++; if (res_peak !== '0) begin bad++; $display("[TB] FAIL reset_peak: got %0d expected 0", res_peak); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %0b expected 0", res_ovf); end
    total++; if (res_drop !== 1'b0) begin bad++; $display("[TB] FAIL reset_drop: got %0b expected 0", res_drop); end
    cycle(); cycle();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle: got valid=%0b expected 0", res_valid); end
    end
  endtask

  task automatic test_seed6();
    int seq [8] = '{3, 10, 5, 16, 8, 4, 2, 1};
    int s;
    load_seed(6);
    start_run();
    total++; if (k !== 20'd6) begin bad++; $display("[TB] FAIL seed6_load: got %0d expected 6", k); end
    for (int i = 0; i < 8; i++) begin
      collatz_step(0, 0);
      s = seq[i];
      total++; if (k !== 20'(s)) begin bad++; $display("[TB] FAIL seed6_k[%0d]: got %0d expected %0d", i, k, s); end
      total++; if (r !== 1'(s & 1)) begin bad++; $display("[TB] FAIL seed6_r[%0d]: got %0b expected %0b", i, r, s & 1); end
    end
    finish_run(0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL seed6_valid: got %0b expected 1", res_valid); end
    total++; if (res_steps !== 16'd8) begin bad++; $display("[TB] FAIL seed6_steps: got %0d expected 8", res_steps); end
    total++; if (res_peak !== 20'(peak_view(16))) begin bad++; $display("[TB] FAIL seed6_peak: got %0d expected %0d", res_peak, peak_view(16)); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("[TB] FAIL seed6_ovf: got %0b expected 0", res_ovf); end
  endtask

  task automatic test_handshake();
    res_ack = 1;
    #2;
    total++; if (res_valid !== 1'b1 || res_steps !== 16'd8) begin bad++; $display("[TB] FAIL hs_hold: got valid=%0b steps=%0d expected valid=1 steps=8", res_valid, res_steps); end
    cycle();
    res_ack = 0; e_valid = 0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL hs_clear: got %0b expected 0", res_valid); end
    cycle();
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL hs_stay_clear: got %0b expected 0", res_valid); end
  endtask

  task automatic test_overflow();
    load_seed(1);
    start_run();
    for (int i = 0; i < 13; i++) begin
      mul_step();
      total++; if (k !== 20'(m_k)) begin bad++; $display("[TB] FAIL ovf_k[%0d]: got %0d expected %0d", i, k, m_k); end
    end
    total++; if (k !== 20'd294332) begin bad++; $display("[TB] FAIL ovf_final_k: got %0d expected 294332", k); end
    finish_run(0);
    total++; if (res_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %0b expected 1", res_ovf); end
    total++; if (res_steps !== 16'd13) begin bad++; $display("[TB] FAIL ovf_steps: got %0d expected 13", res_steps); end
    total++; if (res_peak !== 20'(e_peak)) begin bad++; $display("[TB] FAIL ovf_peak: got %0d expected %0d", res_peak, e_peak); end
    ack_cycle();
  endtask

  task automatic test_seed27_midrun_seed();
    load_seed(27);
    start_run();
    for (int i = 0; i < 5; i++) collatz_step(0, 0);
    collatz_step(1, 99);
    total++; if (co !== 8'd99) begin bad++; $display("[TB] FAIL midrun_co: got %0d expected 99", co); end
    total++; if (k !== 20'(m_k)) begin bad++; $display("[TB] FAIL midrun_k: got %0d expected %0d", k, m_k); end
    for (int g = 0; g < 300 && m_k != 1; g++) begin
      collatz_step(0, 0);
      total++; if (k !== 20'(m_k)) begin bad++; $display("[TB] FAIL s27_k: got %0d expected %0d", k, m_k); end
    end
    finish_run(0);
    total++; if (res_steps !== 16'd111) begin bad++; $display("[TB] FAIL s27_steps: got %0d expected 111", res_steps); end
    total++; if (res_peak !== 20'(peak_view(9232))) begin bad++; $display("[TB] FAIL s27_peak: got %0d expected %0d", res_peak, peak_view(9232)); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("[TB] FAIL s27_ovf: got %0b expected 0", res_ovf); end
    ack_cycle();
  endtask

  task automatic test_random_runs();
    int sd;
    for (int n = 0; n < 6; n++) begin
      sd = $urandom_range(1, 255);
      load_seed(sd);
      start_run();
      for (int g = 0; g < 600 && m_k != 1; g++) begin
        if ($urandom_range(0, 3) == 0) noop_step();
        else collatz_step(0, 0);
        total++; if (k !== 20'(m_k)) begin bad++; $display("[TB] FAIL rnd_k seed=%0d: got %0d expected %0d", sd, k, m_k); end
      end
      finish_run(0);
      total++;
      if (res_valid !== 1'b1 || res_steps !== 16'(e_steps) || res_peak !== 20'(e_peak) || res_ovf !== e_ovf) begin
        bad++;
        $display("[TB] FAIL rnd_record seed=%0d: got v=%0b s=%0d p=%0d o=%0b expected v=1 s=%0d p=%0d o=%0b",
                 sd, res_valid, res_steps, res_peak, res_ovf, e_steps, e_peak, e_ovf);
      end
      ack_cycle();
    end
  endtask

  task automatic run_body(input int sd);
    load_seed(sd);
    start_run();
    for (int g = 0; g < 600 && m_k != 1; g++) collatz_step(0, 0);
  endtask

  task automatic test_simultaneous();
    int a_steps;
    run_body($urandom_range(2, 255));
    finish_run(0);
    a_steps = e_steps;
    run_body($urandom_range(2, 255));
    total++; if (res_valid !== 1'b1 || res_steps !== 16'(a_steps)) begin bad++; $display("[TB] FAIL sim_hold: got v=%0b s=%0d expected v=1 s=%0d", res_valid, res_steps, a_steps); end
    finish_run(1);
    total++; if (res_valid !== 1'b1) begin bad++; $display("[TB] FAIL sim_valid: got %0b expected 1", res_valid); end
    total++; if (res_steps !== 16'(e_steps)) begin bad++; $display("[TB] FAIL sim_steps: got %0d expected %0d", res_steps, e_steps); end
    total++; if (res_drop !== 1'b0) begin bad++; $display("[TB] FAIL sim_drop: got %0b expected 0", res_drop); end
    ack_cycle();
  endtask

  task automatic test_drop();
    run_body(7);
    finish_run(0);
    run_body(9);
    finish_run(0);
    total++; if (res_drop !== e_drop || res_drop !== 1'b1) begin bad++; $display("[TB] FAIL drop_set: got %0b expected 1", res_drop); end
    total++; if (res_steps !== 16'(e_steps) || res_peak !== 20'(e_peak)) begin bad++; $display("[TB] FAIL drop_record: got s=%0d p=%0d expected s=%0d p=%0d", res_steps, res_peak, e_steps, e_peak); end
    ack_cycle();
    total++; if (res_drop !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("[TB] FAIL drop_sticky: got drop=%0b valid=%0b expected drop=1 valid=0", res_drop, res_valid); end
  endtask

  task automatic test_reset_midrun();
    run_body(27);
    finish_run(0);
    load_seed(31);
    start_run();
    for (int i = 0; i < 4; i++) collatz_step(0, 0);
    #3 rst_n = 0;
    #1;
    total++; if (k !== '0 || co !== 8'd0) begin bad++; $display("[TB] FAIL midreset_regs: got k=%0d co=%0d expected 0", k, co); end
    total++; if (res_valid !== 1'b0 || res_drop !== 1'b0 || res_steps !== '0) begin bad++; $display("[TB] FAIL midreset_rec: got v=%0b d=%0b s=%0d expected 0", res_valid, res_drop, res_steps); end
    cycle(); cycle();
    rst_n = 1; ir = 1;
    e_valid = 0; e_drop = 0; m_co = 0; m_k = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_nocap: got %0b expected 0", res_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_seed6();
    test_handshake();
    test_overflow();
    test_seed27_midrun_seed();
    test_random_runs();
    test_simultaneous();
    test_drop();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
